// File: rtl/score_counter_if.sv
// ---------------------------------------------------------------------------
// score_counter_if -- game-side signal bundle for score_counter.
//
//   start        game logic -> counter   level request to begin a new game
//   point_event  game logic -> counter   each rising edge is one scoring event
//   game_over    game logic -> counter   level, ends the current game
//   score_count  counter -> display      current score, binary, 32 bits
//   playing      counter -> game logic   high while a game is in progress
//   score_max    counter -> game logic   high while score is at its ceiling
//   combo_active counter -> game logic   high while the combo window is open
//
// master: the game logic side.  slave: the score counter.
// ---------------------------------------------------------------------------
interface score_counter_if;
    logic        start;
    logic        point_event;
    logic        game_over;
    logic [31:0] score_count;
    logic        playing;
    logic        score_max;
    logic        combo_active;

    modport master (
        output start, point_event, game_over,
        input  score_count, playing, score_max, combo_active
    );

    modport slave (
        input  start, point_event, game_over,
        output score_count, playing, score_max, combo_active
    );
endinterface

// File: rtl/score_counter.sv
// ---------------------------------------------------------------------------
// score_counter -- saturating game score counter with IDLE/PLAYING/OVER FSM.
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   bus   score_counter_if.slave (start, point_event, game_over in;
//         score_count, playing, score_max, combo_active out)
//
// Parameters:
//   MAX_SCORE     saturation ceiling (<= 999 so three BCD digits suffice)
//   POINTS        base increment per counted event
//   COMBO_WINDOW  combo window length in clk cycles
//
// Optional feature: define SCORE_COMBO_EN to build the combo timer. An event
// arriving while the timer is still running scores 2*POINTS. Without the
// macro no timer exists and combo_active is held at 0.
// ---------------------------------------------------------------------------
module score_counter #(
    parameter int unsigned MAX_SCORE    = 999,
    parameter int unsigned POINTS       = 1,
    parameter int unsigned COMBO_WINDOW = 50_000_000
) (
    input  logic            clk,
    input  logic            rst,
    score_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        OVER    = 2'd2
    } state_t;

    localparam logic [31:0] MAX_W    = 32'(MAX_SCORE);
    localparam logic [31:0] POINTS_W = 32'(POINTS);

    state_t      state;
    logic        point_event_q;
    logic [31:0] score_q;
    logic        playing_q;
    logic        score_max_q;
    logic        combo_q;

    logic        event_rise;
    logic [32:0] inc;
    logic [32:0] sum;
    logic [31:0] score_sat;

    // A held-high input produces a single one-cycle pulse here.
    assign event_rise = bus.point_event & ~point_event_q;

`ifdef SCORE_COMBO_EN
    localparam int TW = (COMBO_WINDOW > 1) ? $clog2(COMBO_WINDOW + 1) : 1;
    localparam logic [TW-1:0] WIN = TW'(COMBO_WINDOW);
    localparam logic [TW-1:0] ONE = TW'(1);

    logic [TW-1:0] combo_timer;
`endif

    // Increment and saturating sum. The sum is one bit wider than the score
    // so a large POINTS can never wrap past the ceiling.
    always_comb begin
        inc = {1'b0, POINTS_W};
`ifdef SCORE_COMBO_EN
        if (combo_timer != '0)
            inc = {POINTS_W, 1'b0};
`endif
        sum       = {1'b0, score_q} + inc;
        score_sat = (sum > {1'b0, MAX_W}) ? MAX_W : sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            point_event_q <= 1'b0;
            score_q       <= '0;
            playing_q     <= 1'b0;
            score_max_q   <= 1'b0;
            combo_q       <= 1'b0;
`ifdef SCORE_COMBO_EN
            combo_timer   <= '0;
`endif
        end else begin
            // Edge detector tracks the input in every state so an input
            // already high at game start is not counted.
            point_event_q <= bus.point_event;

`ifdef SCORE_COMBO_EN
            // Free-running countdown; loads and clears below override it.
            // combo_q mirrors the post-edge timer value being non-zero.
            if (combo_timer != '0) begin
                combo_timer <= combo_timer - ONE;
                combo_q     <= (combo_timer != ONE);
            end
`else
            combo_q <= 1'b0;
`endif

            case (state)
                IDLE, OVER: begin
                    // New game: score cleared on the same edge as entry.
                    if (bus.start) begin
                        state       <= PLAYING;
                        playing_q   <= 1'b1;
                        score_q     <= '0;
                        score_max_q <= (MAX_W == 32'd0);
                        combo_q     <= 1'b0;
`ifdef SCORE_COMBO_EN
                        combo_timer <= '0;
`endif
                    end
                end

                PLAYING: begin
                    if (event_rise) begin
                        score_q     <= score_sat;
                        score_max_q <= (score_sat == MAX_W);
`ifdef SCORE_COMBO_EN
                        combo_timer <= WIN;
                        combo_q     <= (WIN != '0);
`endif
                    end
                    // A coincident event has already been scored above;
                    // only the window is torn down on the way to OVER.
                    if (bus.game_over) begin
                        state     <= OVER;
                        playing_q <= 1'b0;
                        combo_q   <= 1'b0;
`ifdef SCORE_COMBO_EN
                        combo_timer <= '0;
`endif
                    end
                end

                default: begin
                    state     <= IDLE;
                    playing_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.score_count  = score_q;
    assign bus.playing      = playing_q;
    assign bus.score_max    = score_max_q;
    assign bus.combo_active = combo_q;

endmodule

// File: tb/tb_score_counter.sv
module tb_score_counter;

    localparam int MAXS = 10;
    localparam int PTS  = 1;
    localparam int WIN  = 8;
`ifdef SCORE_COMBO_EN
    localparam int CE = 1;
`else
    localparam int CE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    score_counter_if bus ();

    score_counter #(
        .MAX_SCORE   (MAXS),
        .POINTS      (PTS),
        .COMBO_WINDOW(WIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: game phase, score, and the edge index of the last
    // counted event. The combo window is "open" while fewer than WIN edges
    // have passed since that event.
    int     m_phase;      // 0 idle, 1 playing, 2 over
    int     m_score;
    bit     m_prev;
    longint m_last;
    longint cyc = 0;
    bit     use_model = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit s, input bit pe, input bit go, input bit r);
        bit rise;
        int inc;
        cyc++;
        if (r) begin
            m_phase = 0; m_score = 0; m_prev = 0; m_last = -1000;
            return;
        end
        rise   = pe && !m_prev;
        m_prev = pe;
        if (m_phase == 1) begin
            if (rise) begin
                inc     = (CE == 1 && (cyc - m_last) <= WIN) ? 2 * PTS : PTS;
                m_score = (m_score + inc > MAXS) ? MAXS : m_score + inc;
                m_last  = cyc;
            end
            if (go) begin
                m_phase = 2; m_last = -1000;
            end
        end else if (s) begin
            m_phase = 1; m_score = 0; m_last = -1000;
        end
    endtask

    task automatic step(input bit s, input bit pe, input bit go, input bit r = 1'b0);
        bus.start       = s;
        bus.point_event = pe;
        bus.game_over   = go;
        rst             = r;
        @(posedge clk);
        model_edge(s, pe, go, r);
        #1;
        if (use_model) begin
            chk("score", 64'(bus.score_count), 64'(m_score));
            chk("playing", 64'(bus.playing), 64'(m_phase == 1));
            chk("score_max", 64'(bus.score_max), 64'(m_score == MAXS));
            chk("combo", 64'(bus.combo_active), 64'(CE == 1 && (cyc - m_last) < WIN));
        end
    endtask

    // One isolated event followed by quiet cycles beyond the combo window.
    task automatic spaced_event();
        step(0, 1, 0);
        for (int i = 0; i < 19; i++) step(0, 0, 0);
    endtask

    typedef struct {
        bit s, pe, go, r;
        int score;
        bit play, smax, combo;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bus.start = 0; bus.point_event = 0; bus.game_over = 0;
        m_phase = 0; m_score = 0; m_prev = 0; m_last = -1000;

        // Reset for two edges, then idle.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("idle_score", 64'(bus.score_count), 64'd0);
        chk("idle_playing", 64'(bus.playing), 64'd0);

        // Hand-computed vectors: {s, pe, go, r, score, playing, max, combo}
        tbl = '{
            '{0,0,0,1, 0,0,0,0},
            '{0,0,0,0, 0,0,0,0},
            '{1,0,0,0, 0,1,0,0},
            '{0,1,0,0, 1,1,0,1},
            '{0,1,0,0, 1,1,0,1},
            '{0,0,1,0, 1,0,0,0},
            '{0,1,0,0, 1,0,0,0},
            '{1,1,0,0, 0,1,0,0},
            '{0,0,0,0, 0,1,0,0},
            '{0,1,0,0, 1,1,0,1},
            '{0,1,0,1, 0,0,0,0},
            '{1,1,0,0, 0,1,0,0},
            '{0,1,0,0, 0,1,0,0},
            '{0,0,1,0, 0,0,0,0}
        };
        use_model = 1'b0;
        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].pe, tbl[i].go, tbl[i].r);
            chk($sformatf("tbl%0d_score", i), 64'(bus.score_count), 64'(tbl[i].score));
            chk($sformatf("tbl%0d_play", i), 64'(bus.playing), 64'(tbl[i].play));
            chk($sformatf("tbl%0d_max", i), 64'(bus.score_max), 64'(tbl[i].smax));
            chk($sformatf("tbl%0d_combo", i), 64'(bus.combo_active), 64'(tbl[i].combo & CE[0]));
        end
        use_model = 1'b1;

        // Five spaced events, each visible one edge after the input rises.
        step(1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            bus.point_event = 1'b1;
            #2;
            chk("pre_edge_score", 64'(bus.score_count), 64'(k - 1));
            spaced_event();
        end
        chk("five_events", 64'(bus.score_count), 64'd5);

        // Held-high input scores exactly once.
        for (int i = 0; i < 30; i++) step(0, 1, 0);
        step(0, 0, 0);
        chk("held_high", 64'(bus.score_count), 64'd6);

        // Saturation at MAX_SCORE, then clear on the next game.
        step(0, 0, 1);
        step(1, 0, 0);
        for (int k = 1; k <= 15; k++) spaced_event();
        chk("sat_score", 64'(bus.score_count), 64'(MAXS));
        chk("sat_max", 64'(bus.score_max), 64'd1);
        step(0, 0, 1);
        step(1, 0, 0);
        chk("clear_score", 64'(bus.score_count), 64'd0);
        chk("clear_max", 64'(bus.score_max), 64'd0);

        // Event coincident with game_over at score 3.
        for (int k = 0; k < 3; k++) spaced_event();
        step(0, 1, 1);
        chk("coinc_score", 64'(bus.score_count), 64'd4);
        chk("coinc_playing", 64'(bus.playing), 64'd0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        chk("over_frozen", 64'(bus.score_count), 64'd4);

        // Combo: events at t, t+4, t+20.
        step(1, 0, 0);
        step(0, 1, 0);
        chk("combo_first", 64'(bus.score_count), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(0, 1, 0);
        chk("combo_second", 64'(bus.score_count), 64'(CE == 1 ? 3 : 2));
        chk("combo_active", 64'(bus.combo_active), 64'(CE));
        for (int i = 0; i < 15; i++) step(0, 0, 0);
        step(0, 1, 0);
        chk("combo_third", 64'(bus.score_count), 64'(CE == 1 ? 4 : 3));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 6), ($urandom_range(99) < 45),
                 ($urandom_range(99) < 3), ($urandom_range(299) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 Parameter MAX_SCORE, default 999, saturation ceiling for score_count (must be <= 999 so three BCD digits downstream suffice).
REQ-002 Parameter POINTS, default 1, base increment per counted point event.
REQ-003 Parameter COMBO_WINDOW, default 50_000_000, combo window length in clk cycles (1 s at 50 MHz).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  level request to begin a new game.
REQ-007 point_event  input  1  level from game logic; each rising edge is one scoring event.
REQ-008 game_over  input  1  level; high ends the current game.
REQ-009 score_count  output  32  current score, binary, registered; feeds score_display.score_count.
REQ-010 playing  output  1  high while FSM is in PLAYING.
REQ-011 score_max  output  1  high while score_count == MAX_SCORE.
REQ-012 combo_active  output  1  high while the combo window timer is non-zero.

Function
REQ-013 FSM states IDLE, PLAYING, OVER; state and all outputs registered.
REQ-014 IDLE: start=1 -> PLAYING, score_count cleared to 0 on the same edge.
REQ-015 PLAYING: game_over=1 -> OVER; start ignored.
REQ-016 OVER: score_count frozen; start=1 -> PLAYING with score_count cleared; game_over ignored.
REQ-017 Event detect: point_event registered once; counted event = point_event & ~point_event_q, so a held-high input scores exactly once.
REQ-018 Events counted only in PLAYING; events in IDLE/OVER are discarded, but point_event_q still tracks the input.
REQ-019 Latency: score_count reflects a counted event on the clk edge after the rising edge of point_event is sampled (1 cycle after input goes high).
REQ-020 Update: score_count <= min(score_count + inc, MAX_SCORE); sum computed at 33 bits so no wrap-around is possible.
REQ-021 At MAX_SCORE further events leave score_count unchanged; score_max stays high until the next clear.
REQ-022 Simultaneous counted event and game_over in PLAYING: event is scored, then the FSM enters OVER on the same edge.
REQ-023 playing asserts on the same edge the FSM enters PLAYING and deasserts on entry to OVER.

Reset
REQ-024 rst=1 on a clk edge: state IDLE, score_count 0, playing 0, score_max 0, combo_active 0, combo timer 0, point_event_q 0.
REQ-025 rst overrides all inputs, including mid-game and mid-combo; the first edge with rst=0 behaves as IDLE.

Configuration
REQ-026 Macro SCORE_COMBO_EN defined: a counted event loads the combo timer with COMBO_WINDOW; the timer decrements each cycle to 0.
REQ-027 With SCORE_COMBO_EN defined, inc = 2*POINTS when a counted event arrives while timer != 0, otherwise inc = POINTS; the timer is cleared on game start and on entry to OVER.
REQ-028 Macro SCORE_COMBO_EN undefined: no timer is built, inc = POINTS always, and combo_active is tied to 0.

Verification
REQ-029 rst 2 cycles, then idle 10 cycles -> score_count=0, playing=0, score_max=0, combo_active=0.
REQ-030 start pulse; 5 point_event pulses spaced 20 cycles (combo off or COMBO_WINDOW=8) -> score_count=5, each step lagging the input by 1 cycle.
REQ-031 point_event held high 30 cycles while PLAYING -> score_count increments by exactly 1.
REQ-032 MAX_SCORE=10, 15 spaced events -> score_count stops at 10 and score_max=1; game_over then start -> score_count=0, score_max=0.
REQ-033 Same cycle point_event rise and game_over at score 3 -> score_count=4, playing=0; further events leave it at 4.
REQ-034 SCORE_COMBO_EN defined, COMBO_WINDOW=8, events at t and t+4 -> +1 then +2 (score 3), combo_active high; next event at t+20 -> +1.
